alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath, replacing the purely combinational ALU in the EX stage. It runs the single-cycle logic/arithmetic ops as a registered, one-cycle operation. It also adds an iterative unsigned multiplier and divider writing HI/LO, and uses a start/busy/done handshake so the pipeline control can stall the EX stage on long operations.

---
 rtl/alu_mc.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
// Single-cycle ops are registered one cycle after acceptance. MULTU (shift-add)
// and DIVU (restoring) iterate one bit per cycle into HI/LO under a
// start/busy/done handshake.
// Build option: define ALU_DIV_EN to include the divider; without it, code
// 1001 is treated as an illegal single-cycle op.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sc_pend_q, sc_pend_d;
  logic [WIDTH-1:0]   r_hi_q, r_hi_d;
  logic [WIDTH-1:0]   r_lo_q, r_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   diff_w;
  logic               slt_w;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_t;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
`endif

  assign out  = out_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

  // Result of the captured single-cycle op, including signed overflow for ADD/SUB.
  always_comb begin
    sum_w  = a_q + b_q;
    diff_w = a_q - b_q;
    slt_w  = $signed(a_q) < $signed(b_q);
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op_q)
      OP_AND:  sc_res = a_q & b_q;
      OP_OR:   sc_res = a_q | b_q;
      OP_ADD: begin
        sc_res = sum_w;
        sc_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff_w;
        sc_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt_w};
      OP_NOR:  sc_res = ~(a_q | b_q);
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  // Next-state logic: acceptance, iteration steps and result write-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sc_pend_d = 1'b0;
    r_hi_d    = r_hi_q;
    r_lo_d    = r_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    out_d     = out_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mul_sum   = '0;
`ifdef ALU_DIV_EN
    div_t     = '0;
    div_sub   = '0;
    div_ge    = 1'b0;
`endif

    // A single-cycle op captured last edge retires now.
    if (sc_pend_q) begin
      out_d  = sc_res;
      zero_d = (sc_res == '0);
      ovf_d  = sc_ovf;
      done_d = 1'b1;
    end

    case (state_q)
      S_MUL: begin
        // {hi,lo} holds partial product in hi and the unconsumed multiplier in lo.
        mul_sum = {1'b0, r_hi_q} + (r_lo_q[0] ? {1'b0, a_q} : '0);
        {r_hi_d, r_lo_d} = {mul_sum, r_lo_q[WIDTH-1:1]};
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        // hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
        div_t   = {r_hi_q, r_lo_q[WIDTH-1]};
        div_sub = div_t - {1'b0, b_q};
        div_ge  = (div_t >= {1'b0, b_q});
        r_hi_d  = div_ge ? div_sub[WIDTH-1:0] : div_t[WIDTH-1:0];
        r_lo_d  = {r_lo_q[WIDTH-2:0], div_ge};
      end
`endif
      S_FIN: begin
        hi_d    = r_hi_q;
        lo_d    = r_lo_q;
        out_d   = r_lo_q;
        zero_d  = (r_lo_q == '0);
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (state_q == S_MUL || state_q == S_DIV) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d   = '0;
        state_d = S_FIN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // busy_q covers MUL, DIV and FIN, so acceptance only happens in IDLE.
    if (start && !busy_q) begin
      op_d = ctrl;
      a_d  = in1;
      b_d  = in2;
      if (ctrl == OP_MULTU) begin
        state_d = S_MUL;
        busy_d  = 1'b1;
        cnt_d   = '0;
        r_hi_d  = '0;
        r_lo_d  = in2;
      end
`ifdef ALU_DIV_EN
      else if (ctrl == OP_DIVU) begin
        state_d = S_DIV;
        busy_d  = 1'b1;
        cnt_d   = '0;
        r_hi_d  = '0;
        r_lo_d  = in1;
      end
`endif
      else begin
        sc_pend_d = 1'b1;
      end
    end
  end

  // State register; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sc_pend_q <= 1'b0;
      r_hi_q    <= '0;
      r_lo_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      out_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sc_pend_q <= sc_pend_d;
      r_hi_q    <= r_hi_d;
      r_lo_q    <= r_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ctrl = 4'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [W-1:0] out;
  logic         zero, ovf, busy, done;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .in1(in1), .in2(in2),
    .out(out), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           cyc = 0;
  int           busy_until = -1;

  // Reference model: on each edge decide acceptance and compute the result arithmetically.
  always @(posedge clk) begin : model
    logic [W-1:0]   r;
    logic           v;
    bit             multi;
    logic [2*W-1:0] p;
    longint         sa, sb;
    exp_t           e;
    cyc = cyc + 1;
    if (rst) begin
      expq.delete();
      m_hi = '0;
      m_lo = '0;
      busy_until = -1;
    end else if (start && cyc > busy_until) begin
      r = '0; v = 1'b0; multi = 1'b0;
      sa = longint'($signed(in1));
      sb = longint'($signed(in2));
      case (ctrl)
        4'b0000: r = in1 & in2;
        4'b0001: r = in1 | in2;
        4'b0010: begin r = in1 + in2; v = ((sa + sb) != longint'($signed(r))); end
        4'b0110: begin r = in1 - in2; v = ((sa - sb) != longint'($signed(r))); end
        4'b0111: r = (sa < sb) ? 1 : 0;
        4'b1100: r = ~(in1 | in2);
        4'b1010: r = m_hi;
        4'b1011: r = m_lo;
        4'b1000: begin
          p = {{W{1'b0}}, in1} * {{W{1'b0}}, in2};
          m_hi = p[2*W-1:W];
          m_lo = p[W-1:0];
          r = m_lo;
          multi = 1'b1;
        end
`ifdef ALU_DIV_EN
        4'b1001: begin
          if (in2 == 0) begin
            m_lo = '1;
            m_hi = in1;
          end else begin
            m_lo = in1 / in2;
            m_hi = in1 % in2;
          end
          r = m_lo;
          multi = 1'b1;
        end
`endif
        default: r = '0;
      endcase
      e.res = r;
      e.v   = v;
      e.cyc = multi ? cyc + W + 1 : cyc + 1;
      if (multi) busy_until = cyc + W + 1;
      expq.push_back(e);
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    bit exp_done;
    if (rst) begin
      check("reset_state", {out, zero, ovf, busy, done}, '0);
    end else begin
      while (expq.size() > 0 && expq[0].cyc < cyc) void'(expq.pop_front());
      exp_done = (expq.size() > 0) && (expq[0].cyc == cyc);
      check("done", done, exp_done);
      check("busy", busy, (cyc < busy_until));
      if (exp_done) begin
        if (done) begin
          check("out", out, expq[0].res);
          check("zero", zero, (expq[0].res == '0));
          check("ovf", ovf, expq[0].v);
        end
        void'(expq.pop_front());
      end
    end
  end

  // Issue one op and wait for done; optionally pulse a start while busy.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit now, input int poke,
                        output logic [W-1:0] r, output logic z, output logic v, output int lat);
    if (!now) @(negedge clk);
    start = 1'b1; ctrl = c; in1 = a; in2 = b;
    lat = 0; r = '0; z = 1'b0; v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      start = 1'b0; ctrl = 4'b0010; in1 = $urandom; in2 = $urandom;
      if (lat == poke) start = 1'b1;
      if (done) begin
        r = out; z = zero; v = ovf;
        lat = lat - 1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout op %0h: no done within 100 cycles", c);
    lat = -1;
  endtask

  logic [W-1:0] r;
  logic         z, v;
  int           lat;
  logic [3:0]   ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                            4'b1100, 4'b1010, 4'b1011, 4'b0011};
  logic [W-1:0] vals [6] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h5};

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, r, z, v, lat);
    check("add_out", r, 32'h8000_0000);
    check("add_ovf", v, 1'b1);
    check("add_zero", z, 1'b0);
    check("add_lat", lat, 1);

    run_op(4'b0110, 32'd5, 32'd5, 1'b0, 0, r, z, v, lat);
    check("sub_out", r, 0);
    check("sub_zero", z, 1'b1);
    check("sub_ovf", v, 1'b0);

    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, r, z, v, lat);
    check("slt_out", r, 1);
    run_op(4'b1100, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("nor_out", r, 32'hFFFF_FFFF);
    run_op(4'b0011, 32'h5, 32'h3, 1'b0, 0, r, z, v, lat);
    check("illegal_out", r, 0);
    check("illegal_zero", z, 1'b1);

    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, r, z, v, lat);
    check("multu_lat", lat, 33);
    check("multu_lo", r, 32'h0000_0001);
    run_op(4'b1010, 32'h0, 32'h0, 1'b1, 0, r, z, v, lat);
    check("multu_hi", r, 32'hFFFF_FFFE);
    run_op(4'b1011, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("multu_mflo", r, 32'h0000_0001);

`ifdef ALU_DIV_EN
    run_op(4'b1001, 32'd100, 32'd7, 1'b0, 0, r, z, v, lat);
    check("divu_lat", lat, 33);
    check("divu_lo", r, 14);
    run_op(4'b1010, 32'h0, 32'h0, 1'b1, 0, r, z, v, lat);
    check("divu_hi", r, 2);
    run_op(4'b1001, 32'd9, 32'd0, 1'b0, 0, r, z, v, lat);
    check("div0_lo", r, 32'hFFFF_FFFF);
    run_op(4'b1010, 32'h0, 32'h0, 1'b1, 0, r, z, v, lat);
    check("div0_hi", r, 9);
`else
    run_op(4'b1001, 32'd100, 32'd7, 1'b0, 0, r, z, v, lat);
    check("nodiv_lat", lat, 1);
    check("nodiv_out", r, 0);
    check("nodiv_zero", z, 1'b1);
    run_op(4'b1010, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("nodiv_hi", r, 32'hFFFF_FFFE);
    run_op(4'b1011, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("nodiv_lo", r, 32'h0000_0001);
`endif

    // Back-to-back single-cycle ops, one start per cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b1;
      ctrl  = ops[$urandom_range(0, 8)];
      in1   = ($urandom_range(0, 1) == 1) ? W'($urandom) : vals[$urandom_range(0, 5)];
      in2   = ($urandom_range(0, 1) == 1) ? W'($urandom) : vals[$urandom_range(0, 5)];
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a multiply.
    start = 1'b1; ctrl = 4'b1000; in1 = 32'hFFFF_FFFF; in2 = 32'h2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_out", out, 0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(4'b1011, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("rst_mflo", r, 0);
    run_op(4'b1010, 32'h0, 32'h0, 1'b0, 0, r, z, v, lat);
    check("rst_mfhi", r, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
